// File: rtl/hbridge_deadtime.sv
// H-bridge gate stage: three-level SPWM command in, four dead-time-protected gates out.
// Optional HBRIDGE_MIN_ON_EN adds a minimum high-side on-time per leg.

module hbridge_deadtime_leg #(
  parameter int DT_CYCLES = 16,
  parameter int NB_DT     = 8,
  parameter int MIN_ON    = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_kill,
  input  logic i_req_high,
  output logic o_hi_on,
  output logic o_lo_on,
  output logic o_active
);

  typedef enum logic [2:0] {
    S_OFF,
    S_LOW,
    S_RISE,
    S_HIGH,
    S_FALL
  } state_t;

  localparam logic [NB_DT-1:0] DT_RELOAD = NB_DT'(DT_CYCLES - 1);

  if (DT_CYCLES < 1 || DT_CYCLES > (2 ** NB_DT) - 1 || MIN_ON < 1) begin : g_bad_params
    $error("hbridge_deadtime_leg: DT_CYCLES must fit NB_DT and MIN_ON must be >= 1");
  end

  state_t           state_q, state_d;
  logic [NB_DT-1:0] cnt_q, cnt_d;
  logic             dt_done;
  logic             min_on_met;

`ifdef HBRIDGE_MIN_ON_EN
  localparam int NB_ON = (MIN_ON > 1) ? $clog2(MIN_ON + 1) : 1;
  localparam logic [NB_ON-1:0] ON_LAST = NB_ON'(MIN_ON - 1);

  logic [NB_ON-1:0] on_cnt_q, on_cnt_d;

  // Counts completed HIGH cycles; restarts on every entry into HIGH.
  always_comb begin
    on_cnt_d = on_cnt_q;
    if (state_q != S_HIGH) begin
      on_cnt_d = '0;
    end else if (on_cnt_q != ON_LAST) begin
      on_cnt_d = on_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      on_cnt_q <= '0;
    end else begin
      on_cnt_q <= on_cnt_d;
    end
  end

  assign min_on_met = (on_cnt_q >= ON_LAST);
`else
  assign min_on_met = 1'b1;
`endif

  assign dt_done = (cnt_q == '0);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    if (i_kill) begin
      state_d = S_OFF;
      cnt_d   = DT_RELOAD;
    end else begin
      unique case (state_q)
        S_OFF: begin
          if (dt_done) state_d = S_LOW;
          else         cnt_d   = cnt_q - 1'b1;
        end
        S_LOW: begin
          if (i_req_high) begin
            state_d = S_RISE;
            cnt_d   = DT_RELOAD;
          end
        end
        S_RISE: begin
          if (!i_req_high)  state_d = S_LOW;
          else if (dt_done) state_d = S_HIGH;
          else              cnt_d   = cnt_q - 1'b1;
        end
        S_HIGH: begin
          if (!i_req_high && min_on_met) begin
            state_d = S_FALL;
            cnt_d   = DT_RELOAD;
          end
        end
        S_FALL: begin
          if (i_req_high)   state_d = S_HIGH;
          else if (dt_done) state_d = S_LOW;
          else              cnt_d   = cnt_q - 1'b1;
        end
        default: begin
          state_d = S_OFF;
          cnt_d   = DT_RELOAD;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_OFF;
      cnt_q   <= DT_RELOAD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_hi_on  = (state_q == S_HIGH);
  assign o_lo_on  = (state_q == S_LOW);
  assign o_active = (state_q != S_OFF);

endmodule

module hbridge_deadtime #(
  parameter int DT_CYCLES = 16,
  parameter int NB_DT     = 8,
  parameter int MIN_ON    = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [1:0] i_pwm,
  input  logic       i_fault,
  input  logic       i_fault_clr,
  output logic [3:0] o_gate,
  output logic       o_fault,
  output logic       o_ready
);

  logic [1:0] r_pwm_q;
  logic       fault_q, fault_d;
  logic [3:0] gate_q, gate_d;
  logic       kill_state, kill_gate;
  logic       a_hi, a_lo, a_act;
  logic       b_hi, b_lo, b_act;

  assign kill_state = !i_en || fault_q;
  // A raw fault blanks the gates at the same edge that latches o_fault.
  assign kill_gate  = kill_state || i_fault;
  assign fault_d    = i_fault || (fault_q && !i_fault_clr);

  hbridge_deadtime_leg #(
    .DT_CYCLES (DT_CYCLES),
    .NB_DT     (NB_DT),
    .MIN_ON    (MIN_ON)
  ) u_leg_a (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_kill     (kill_state),
    .i_req_high (r_pwm_q == 2'b01),
    .o_hi_on    (a_hi),
    .o_lo_on    (a_lo),
    .o_active   (a_act)
  );

  hbridge_deadtime_leg #(
    .DT_CYCLES (DT_CYCLES),
    .NB_DT     (NB_DT),
    .MIN_ON    (MIN_ON)
  ) u_leg_b (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_kill     (kill_state),
    .i_req_high (r_pwm_q == 2'b11),
    .o_hi_on    (b_hi),
    .o_lo_on    (b_lo),
    .o_active   (b_act)
  );

  assign gate_d = kill_gate ? 4'b0000 : {b_lo, b_hi, a_lo, a_hi};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pwm_q <= 2'b00;
      fault_q <= 1'b0;
      gate_q  <= 4'b0000;
    end else begin
      r_pwm_q <= i_pwm;
      fault_q <= fault_d;
      gate_q  <= gate_d;
    end
  end

  assign o_gate  = gate_q;
  assign o_fault = fault_q;
  assign o_ready = a_act && b_act;

endmodule

// File: tb/tb_hbridge_deadtime.sv
// Self-checking bench for hbridge_deadtime: per-cycle comparison against a
// behavioural leg model plus directed hand-computed checkpoints (DT_CYCLES=4).

module tb_hbridge_deadtime;

  localparam int DT     = 4;
  localparam int MIN_ON = 8;
`ifdef HBRIDGE_MIN_ON_EN
  localparam int MIN_ON_EFF = MIN_ON;
`else
  localparam int MIN_ON_EFF = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] pwm;
  logic       fault;
  logic       clr;
  logic [3:0] o_gate;
  logic       o_fault;
  logic       o_ready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hbridge_deadtime #(
    .DT_CYCLES (DT),
    .NB_DT     (8),
    .MIN_ON    (MIN_ON)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_pwm       (pwm),
    .i_fault     (fault),
    .i_fault_clr (clr),
    .o_gate      (o_gate),
    .o_fault     (o_fault),
    .o_ready     (o_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: each leg conducts nothing (0), its low switch (1) or its high switch (2).
  // prev = side conducting before the current blank (0 = startup from off).
  int         m_cond [2];
  int         m_prev [2];
  int         m_to   [2];
  int         m_blank[2];
  int         m_hi_n [2];
  logic       m_fault;
  logic [1:0] m_pwm;
  logic [3:0] exp_gate;
  logic       exp_ready;

  always @(posedge clk or posedge rst) begin : model
    logic kill_s, kill_g;
    int   want[2];
    if (rst) begin
      for (int l = 0; l < 2; l++) begin
        m_cond[l] = 0; m_prev[l] = 0; m_to[l] = 1; m_blank[l] = 0; m_hi_n[l] = 0;
      end
      m_fault   = 1'b0;
      m_pwm     = 2'b00;
      exp_gate  = 4'b0000;
      exp_ready = 1'b0;
    end else begin
      kill_s   = !en || m_fault;
      kill_g   = kill_s || fault;
      exp_gate = kill_g ? 4'b0000 :
                 {m_cond[1] == 1, m_cond[1] == 2, m_cond[0] == 1, m_cond[0] == 2};
      want[0]  = (m_pwm == 2'b01) ? 2 : 1;
      want[1]  = (m_pwm == 2'b11) ? 2 : 1;
      for (int l = 0; l < 2; l++) begin
        if (kill_s) begin
          m_cond[l] = 0; m_prev[l] = 0; m_to[l] = 1; m_blank[l] = 0;
        end else if (m_cond[l] == 0) begin
          if (m_prev[l] != 0 && want[l] == m_prev[l]) begin
            m_cond[l] = m_prev[l];
            m_hi_n[l] = 0;
          end else begin
            m_blank[l]++;
            if (m_blank[l] == DT) begin
              m_cond[l] = m_to[l];
              m_prev[l] = m_to[l];
              m_hi_n[l] = 0;
            end
          end
        end else begin
          if (m_cond[l] == 2) m_hi_n[l]++;
          if (want[l] != m_cond[l] && !(m_cond[l] == 2 && m_hi_n[l] < MIN_ON_EFF)) begin
            m_prev[l]  = m_cond[l];
            m_to[l]    = want[l];
            m_cond[l]  = 0;
            m_blank[l] = 0;
          end
        end
      end
      m_fault   = fault || (m_fault && !clr);
      m_pwm     = pwm;
      exp_ready = !(m_cond[0] == 0 && m_prev[0] == 0) && !(m_cond[1] == 0 && m_prev[1] == 0);
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("cyc_gate", 32'(o_gate), 32'(exp_gate));
      check("cyc_fault", 32'(o_fault), 32'(m_fault));
      check("cyc_ready", 32'(o_ready), 32'(exp_ready));
      check("cyc_overlap", 32'({o_gate[3] & o_gate[2], o_gate[1] & o_gate[0]}), 32'd0);
    end
  end

  logic [1:0] vec_pwm [12] = '{2'b01, 2'b11, 2'b01, 2'b00, 2'b11, 2'b01,
                               2'b11, 2'b00, 2'b10, 2'b01, 2'b11, 2'b00};
  int         vec_len [12] = '{1, 2, 3, 5, 6, 4, 1, 3, 6, 9, 12, 10};

  initial begin
    rst = 1'b1; en = 1'b1; pwm = 2'b00; fault = 1'b0; clr = 1'b0;
    #2;
    check("rst_gate", 32'(o_gate), 32'h0);
    check("rst_fault", 32'(o_fault), 32'h0);
    check("rst_ready", 32'(o_ready), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Startup: DT edges in OFF, gates follow one edge later.
    step(3); check("start_gate", 32'(o_gate), 32'h0); check("start_ready", 32'(o_ready), 32'h0);
    step(1); check("start_rdy4", 32'(o_ready), 32'h1); check("start_gate4", 32'(o_gate), 32'h0);
    step(1); check("start_low", 32'(o_gate), 32'b1010);

    // Zero -> +1
    pwm = 2'b01;
    step(2); check("zp_k1", 32'(o_gate), 32'b1010);
    step(1); check("zp_s2_drop", 32'(o_gate), 32'b1000);
    step(3); check("zp_dead", 32'(o_gate), 32'b1000);
    step(1); check("zp_s1_on", 32'(o_gate), 32'b1001);

    // +1 -> -1: both legs blank together
    pwm = 2'b11;
    step(2); check("pm_k1", 32'(o_gate), 32'b1001);
    step(1); check("pm_drop", 32'(o_gate), 32'b0000);
    step(3); check("pm_dead", 32'(o_gate), 32'b0000);
    step(1); check("pm_on", 32'(o_gate), 32'b0110);
    pwm = 2'b00;
    step(8); check("mz_low", 32'(o_gate), 32'b1010);

    // Abort: +1 held two cycles
    pwm = 2'b01;
    step(2); pwm = 2'b00; check("ab_k1", 32'(o_gate), 32'b1010);
    step(1); check("ab_off1", 32'(o_gate), 32'b1000);
    step(1); check("ab_off2", 32'(o_gate), 32'b1000);
    step(1); check("ab_back", 32'(o_gate), 32'b1010);

    // Fault while leg A is high
    pwm = 2'b01;
    step(8); check("ft_high", 32'(o_gate), 32'b1001);
    fault = 1'b1;
    step(1); fault = 1'b0;
    check("ft_gate", 32'(o_gate), 32'h0); check("ft_flag", 32'(o_fault), 32'h1);
    fault = 1'b1; clr = 1'b1;
    step(1); fault = 1'b0; clr = 1'b0;
    check("ft_clr_blocked", 32'(o_fault), 32'h1);
    step(2); check("ft_hold", 32'(o_fault), 32'h1); check("ft_ready", 32'(o_ready), 32'h0);
    clr = 1'b1;
    step(1); clr = 1'b0;
    check("ft_cleared", 32'(o_fault), 32'h0); check("ft_clr_gate", 32'(o_gate), 32'h0);
    step(3); check("ft_off3", 32'(o_ready), 32'h0);
    step(1); check("ft_off4", 32'(o_ready), 32'h1);
    step(1); check("ft_low", 32'(o_gate), 32'b1010);
    step(5); check("ft_resume", 32'(o_gate), 32'b1001);

    // Enable drop and restart
    en = 1'b0;
    step(1); check("en_gate", 32'(o_gate), 32'h0); check("en_ready", 32'(o_ready), 32'h0);
    step(2); en = 1'b1;
    step(3); check("en_off3", 32'(o_ready), 32'h0);
    step(1); check("en_off4", 32'(o_ready), 32'h1);
    step(1); check("en_low", 32'(o_gate), 32'b1010);

    // Short high request: min-on stretches S1 to MIN_ON cycles
    step(5); check("mo_s1_on", 32'(o_gate), 32'b1001);
    step(2); pwm = 2'b00;
`ifdef HBRIDGE_MIN_ON_EN
    step(3); check("mo_e15", 32'(o_gate), 32'b1001);
    step(2); check("mo_e17", 32'(o_gate), 32'b1001);
`else
    step(3); check("mo_e15", 32'(o_gate), 32'b1000);
    step(2); check("mo_e17", 32'(o_gate), 32'b1000);
`endif
    step(1); check("mo_e18", 32'(o_gate), 32'b1000);

    // Mixed command vectors, checked per cycle by the model
    for (int i = 0; i < 12; i++) begin
      pwm = vec_pwm[i];
      step(vec_len[i]);
    end
    step(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
